// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads to a one-cycle-latency
// instruction memory and buffers the {instruction, pc} pairs in a small FIFO
// for decode. A taken jump flushes the queue and restarts fetching at the
// target. Fetching stops after a HALT word (opcode 4'hF) is captured.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_fetchEnable,
    output logic [15:0] mem_fetchAddr,
    input  logic [15:0] mem_fetchData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instruction,
    output logic [15:0] out_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [15:0]      pcReg;
    logic [PTR_W-1:0] headReg;
    logic [PTR_W-1:0] tailReg;
    logic [CNT_W-1:0] countReg;
    logic             inflightReg;
    logic [15:0]      inflightPcReg;
    logic             haltedReg;

    logic [15:0] instrMem [DEPTH];
    logic [15:0] pcMem    [DEPTH];

    logic [CNT_W-1:0] occupancy;
    logic             creditOk;
    logic             haltReturning;
    logic             pushEn;
    logic             popEn;

    // Fetch credit, halt lookahead and FIFO handshakes. A pop in the current
    // cycle does not free a credit, so the queue can never overflow.
    always_comb begin
        occupancy       = countReg + CNT_W'(inflightReg);
        creditOk        = occupancy < CNT_W'(DEPTH);
        haltReturning   = inflightReg && (mem_fetchData[15:12] == 4'hF);
        mem_fetchEnable = !reset && !redirect && !haltedReg && !haltReturning && creditOk;
        mem_fetchAddr   = pcReg;
        out_valid       = (countReg != '0) && !reset;
        out_instruction = instrMem[headReg];
        out_pc          = pcMem[headReg];
        pushEn          = inflightReg && !redirect && !reset;
        popEn           = out_valid && out_ready && !redirect;
    end

    // Entry storage: the returning word is written at the tail.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            instrMem[tailReg] <= mem_fetchData;
            pcMem[tailReg]    <= inflightPcReg;
        end
    end

    // Control state: reset beats redirect, redirect flushes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg         <= PC_RESET;
            headReg       <= '0;
            tailReg       <= '0;
            countReg      <= '0;
            inflightReg   <= 1'b0;
            inflightPcReg <= '0;
            haltedReg     <= 1'b0;
        end else if (redirect) begin
            pcReg       <= redirect_pc;
            headReg     <= '0;
            tailReg     <= '0;
            countReg    <= '0;
            inflightReg <= 1'b0;
            haltedReg   <= 1'b0;
        end else begin
            inflightReg <= mem_fetchEnable;
            if (mem_fetchEnable) begin
                pcReg         <= pcReg + 16'd1;
                inflightPcReg <= pcReg;
            end
            if (pushEn) begin
                tailReg <= tailReg + PTR_W'(1);
                if (haltReturning)
                    haltedReg <= 1'b1;
            end
            if (popEn)
                headReg <= headReg + PTR_W'(1);
            countReg <= countReg + CNT_W'(pushEn) - CNT_W'(popEn);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a memory responder, a program-order reference model
// (expected delivery stream rebuilt on every reset/redirect) and a monitor
// that checks every fetch and every accepted queue entry.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] PC_RESET = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_fetchEnable;
    logic [15:0] mem_fetchAddr;
    logic [15:0] mem_fetchData;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instruction;
    logic [15:0] out_pc;

    fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_fetchEnable(mem_fetchEnable),
        .mem_fetchAddr(mem_fetchAddr),
        .mem_fetchData(mem_fetchData),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instruction),
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    int          errs = 0;
    int          checks = 0;
    int          delivCount = 0;
    ent_t        expQ[$];
    logic        haltEn = 1'b0;
    logic [15:0] haltAddr = 16'h0;

    // Program image: one HALT word at haltAddr when enabled, else 1xxx words.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        if (haltEn && a == haltAddr)
            return 16'hF025;
        return {4'h1, a[11:0]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream after a restart at t: sequential pcs up to and
    // including the first HALT word.
    function automatic void restartModel(input logic [15:0] t);
        logic [15:0] a;
        expQ.delete();
        a = t;
        for (int i = 0; i < 200; i++) begin
            expQ.push_back({memWord(a), a});
            if (haltEn && a == haltAddr)
                break;
            a = a + 16'd1;
        end
    endfunction

    // Memory responder: data for a fetch seen in cycle k appears in cycle k+1.
    logic        pendValid = 1'b0;
    logic [15:0] pendAddr = 16'h0;
    always @(negedge clk) begin
        pendValid = mem_fetchEnable;
        pendAddr  = mem_fetchAddr;
    end
    initial begin
        mem_fetchData = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_fetchData = pendValid ? memWord(pendAddr) : 16'($urandom);
        end
    end

    // Monitor: fetch address sequence, credit limit, flush behaviour and
    // scoreboard comparison of every accepted entry.
    logic        prevFlush = 1'b0;
    logic [15:0] expFetch = 16'h0;
    int          outstanding = 0;
    always @(negedge clk) begin
        if (reset || redirect) begin
            check("fetch_en_during_flush", 16'(mem_fetchEnable), 16'h0);
            if (reset)
                check("valid_during_reset", 16'(out_valid), 16'h0);
            expFetch    = reset ? PC_RESET : redirect_pc;
            outstanding = 0;
            prevFlush   = 1'b1;
        end else begin
            if (prevFlush) begin
                check("valid_after_flush", 16'(out_valid), 16'h0);
                check("fetch_after_flush", 16'(mem_fetchEnable), 16'h1);
            end
            prevFlush = 1'b0;
            if (mem_fetchEnable) begin
                check("fetch_addr", mem_fetchAddr, expFetch);
                checks++;
                if (outstanding >= DEPTH) begin
                    errs++;
                    $display("FAIL fetch_credit: got outstanding %0d expected below %0d", outstanding, DEPTH);
                end
                expFetch    = expFetch + 16'd1;
                outstanding = outstanding + 1;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL extra_delivery: got pc %h expected none", out_pc);
                end else begin
                    ent_t e;
                    e = expQ.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instruction", out_instruction, e.instr);
                end
                delivCount  = delivCount + 1;
                outstanding = outstanding - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          d0;
    int          fetchCnt;
    int          guard;
    logic [15:0] lastAddr;
    logic [15:0] maxA;

    // Directed scenarios followed by a randomized run.
    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; out_ready = 1'b1;
        restartModel(PC_RESET);

        // Sequential streaming and first-word latency.
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("first_fetch_en", 16'(mem_fetchEnable), 16'h1);
        check("first_fetch_addr", mem_fetchAddr, PC_RESET);
        tick();
        @(negedge clk);
        check("valid_latency_1", 16'(out_valid), 16'h0);
        tick();
        @(negedge clk);
        check("valid_latency_2", 16'(out_valid), 16'h1);
        tick();
        d0 = delivCount;
        repeat (8) tick();
        check("one_per_cycle", 16'(delivCount - d0), 16'd8);

        // Backpressure: exactly DEPTH fetches, then drain and resume.
        reset = 1'b1; out_ready = 1'b0; restartModel(PC_RESET);
        tick(); tick();
        reset = 1'b0;
        fetchCnt = 0; lastAddr = 16'hFFFF;
        repeat (10) begin
            @(negedge clk);
            if (mem_fetchEnable) begin
                fetchCnt++;
                lastAddr = mem_fetchAddr;
            end
            tick();
        end
        check("full_fetch_count", 16'(fetchCnt), 16'(DEPTH));
        check("full_last_addr", lastAddr, 16'(DEPTH - 1));
        @(negedge clk);
        check("full_stall", 16'(mem_fetchEnable), 16'h0);
        check("full_valid", 16'(out_valid), 16'h1);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_not_credited", 16'(mem_fetchEnable), 16'h0);
        tick();
        @(negedge clk);
        check("resume_fetch_en", 16'(mem_fetchEnable), 16'h1);
        check("resume_fetch_addr", mem_fetchAddr, 16'(DEPTH));
        repeat (6) tick();

        // HALT at address 3.
        reset = 1'b1; haltEn = 1'b1; haltAddr = 16'h0003; restartModel(PC_RESET);
        tick(); tick();
        reset = 1'b0;
        d0 = delivCount; maxA = 16'h0;
        repeat (30) begin
            @(negedge clk);
            if (mem_fetchEnable && mem_fetchAddr > maxA)
                maxA = mem_fetchAddr;
            tick();
        end
        check("halt_deliveries", 16'(delivCount - d0), 16'd4);
        check("halt_max_fetch", maxA, 16'h0003);
        @(negedge clk);
        check("halt_valid_low", 16'(out_valid), 16'h0);
        check("halt_fetch_low", 16'(mem_fetchEnable), 16'h0);
        tick();

        // Redirect with a partly full queue and a word in flight.
        reset = 1'b1; haltEn = 1'b0; restartModel(PC_RESET);
        tick(); tick();
        reset = 1'b0;
        d0 = delivCount; guard = 0;
        while (delivCount - d0 < 5 && guard < 50) begin
            tick();
            guard++;
        end
        check("redirect_setup", 16'(delivCount - d0), 16'd5);
        out_ready = 1'b0;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 16'h0040; out_ready = 1'b1;
        restartModel(16'h0040);
        @(negedge clk);
        check("redirect_queue_nonempty", 16'(out_valid), 16'h1);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("redirect_target_fetch", mem_fetchAddr, 16'h0040);
        tick();
        d0 = delivCount;
        repeat (10) tick();
        check("redirect_progress", 16'(delivCount - d0 >= 8), 16'h1);

        // Redirect near the top of the address space: pc wraps.
        redirect = 1'b1; redirect_pc = 16'hFFFE; restartModel(16'hFFFE);
        tick();
        redirect = 1'b0;
        d0 = delivCount;
        repeat (8) tick();
        check("wrap_progress", 16'(delivCount - d0 >= 4), 16'h1);

        // Reset with count=3 and one word in flight.
        reset = 1'b1; restartModel(PC_RESET);
        tick(); tick();
        reset = 1'b0; out_ready = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("reset_setup_valid", 16'(out_valid), 16'h1);
        tick();
        reset = 1'b1; out_ready = 1'b1; restartModel(PC_RESET);
        tick();
        reset = 1'b0;
        d0 = delivCount;
        repeat (6) tick();
        check("reset_progress", 16'(delivCount - d0 >= 3), 16'h1);

        // Randomized ready pattern, redirects and halts.
        reset = 1'b1; haltEn = 1'b0; restartModel(PC_RESET);
        tick();
        reset = 1'b0;
        d0 = delivCount;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 4) begin
                redirect    = 1'b1;
                redirect_pc = 16'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    haltEn   = 1'b1;
                    haltAddr = redirect_pc + 16'($urandom_range(0, 6));
                end else begin
                    haltEn = 1'b0;
                end
                restartModel(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect = 1'b0;
        repeat (4) tick();
        check("random_progress", 16'(delivCount - d0 > 50), 16'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
